mem_request_arbiter: RTL and testbench

- Parametrised successor to the single-port instruction/data request unit.
- Arbitrates NCH independent memory-request channels onto one shared memory port; channel 0 is icache/imem, channel 1 is dcache/dmem, higher channels are coprocessor/DMA clients.
- Latches the granted request, holds it stable on the memory port until the memory ready, then returns a one-cycle hit plus load data to the owner.
- Supports round-robin or fixed-priority arbitration, selected by parameter.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_picker.sv | 64 ++++++
 rtl/mem_request_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_request_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the memory request arbiter and its helpers.
//   arb_state_t : controller state (IDLE waiting for a request, BUSY holding
//                 a latched access on the memory port)
//   arb_op_t    : kind of the latched access
//   ARB_MAX_CH  : largest supported number of request channels
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_MAX_CH = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational winner selection over a request vector.
//   MODE = 0 : round-robin, first requester at or after ptr_i, wrapping
//   MODE = 1 : fixed priority, highest requesting index wins
// Ports:
//   req_i      [NCH]        request vector
//   ptr_i      [clog2(NCH)] round-robin start position (ignored in MODE 1)
//   found_o                 at least one request present
//   idx_o      [clog2(NCH)] winning channel index (0 when nothing found)
//   next_ptr_o [clog2(NCH)] idx_o + 1 wrapped modulo NCH
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NCH  = 2,
  parameter int MODE = 0
) (
  input  logic [NCH-1:0]         req_i,
  input  logic [$clog2(NCH)-1:0] ptr_i,
  output logic                   found_o,
  output logic [$clog2(NCH)-1:0] idx_o,
  output logic [$clog2(NCH)-1:0] next_ptr_o
);

  localparam int PW = $clog2(NCH);

  logic [2*NCH-1:0] reqTwice;
  logic [NCH-1:0]   rotated;
  int               sum;

  // Rotating a doubled copy puts the channel at ptr_i into bit 0, so the
  // lowest set bit of 'rotated' is the round-robin winner's offset.
  assign reqTwice = {req_i, req_i};
  assign rotated  = NCH'(reqTwice >> ptr_i);

  // Winner search. Both loops overwrite on every hit, so the highest index
  // wins in fixed-priority mode and the descending scan leaves the smallest
  // offset in round-robin mode.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = 0;
    if (MODE != 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (req_i[i]) begin
          found_o = 1'b1;
          idx_o   = PW'(i);
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (rotated[k]) begin
          found_o = 1'b1;
          sum     = int'(ptr_i) + k;
        end
      end
      if (sum >= NCH) begin
        sum = sum - NCH;
      end
      idx_o = PW'(sum);
    end
    next_ptr_o = (idx_o == PW'(NCH - 1)) ? '0 : idx_o + PW'(1);
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// mem_request_arbiter
// Arbitrates NCH memory-request channels onto one shared memory port.
// Channel 0 is imem, channel 1 is dmem, higher channels are coprocessor/DMA
// clients. The granted request is latched and held on the memory port until
// mem_ready, then a one-cycle hit with load data is returned to its owner.
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   req_ren/req_wen [NCH]  per-channel read/write request (both = write)
//   req_addr  [NCH*AW]     per-channel address, channel i at [i*AW +: AW]
//   req_store [NCH*DW]     per-channel write data
//   req_hit   [NCH]        one-hot completion strobe
//   req_load  [DW]         read data, valid with req_hit, 0 otherwise
//   mem_ren/mem_wen        memory enables, only while BUSY
//   mem_addr/mem_store     latched address/data, only while BUSY
//   mem_ready, mem_load    memory completion and read data
//   busy                   transaction in flight
//   grant_id               owner of the current transaction
// ---------------------------------------------------------------------------
module mem_request_arbiter #(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCH-1:0]         req_ren,
  input  logic [NCH-1:0]         req_wen,
  input  logic [NCH*AW-1:0]      req_addr,
  input  logic [NCH*DW-1:0]      req_store,
  output logic [NCH-1:0]         req_hit,
  output logic [DW-1:0]          req_load,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_store,
  input  logic                   mem_ready,
  input  logic [DW-1:0]          mem_load,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] grant_id
);

  import arb_pkg::*;

  localparam int GW = $clog2(NCH);

  if (NCH < 2 || NCH > ARB_MAX_CH) begin : g_badNch
    $error("mem_request_arbiter: NCH must lie in 2..8");
  end

  arb_state_t    state_q, state_d;
  arb_op_t       op_q, op_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] store_q, store_d;

  logic [NCH-1:0] reqAny;
  logic           pickFound;
  logic [GW-1:0]  pickIdx;
  logic [GW-1:0]  pickNext;

  assign reqAny   = req_ren | req_wen;
  assign grant_id = grant_q;

  rr_picker #(
    .NCH  (NCH),
    .MODE (PRIO_MODE)
  ) u_picker (
    .req_i      (reqAny),
    .ptr_i      (ptr_q),
    .found_o    (pickFound),
    .idx_o      (pickIdx),
    .next_ptr_o (pickNext)
  );

  // State and latched-request registers. Reset drops any in-flight access
  // and restarts the round-robin scan at channel 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

  // Next-state and output logic. The memory port is fed only from the
  // latched registers, so channel inputs cannot disturb an access in flight.
  // In BUSY, mem_ready is tested before the owner's request so that a
  // completion arriving in the same cycle as an abort still issues the hit.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    store_d   = store_q;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_store = '0;
    req_hit   = '0;
    req_load  = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          state_d = BUSY;
          grant_d = pickIdx;
          op_d    = req_wen[pickIdx] ? OP_WRITE : OP_READ;
          addr_d  = req_addr[pickIdx*AW +: AW];
          store_d = req_store[pickIdx*DW +: DW];
          if (PRIO_MODE == 0) begin
            ptr_d = pickNext;
          end
        end
      end
      BUSY: begin
        busy      = 1'b1;
        mem_ren   = (op_q == OP_READ);
        mem_wen   = (op_q == OP_WRITE);
        mem_addr  = addr_q;
        mem_store = store_q;
        if (mem_ready) begin
          req_hit[grant_q] = 1'b1;
          req_load         = mem_load;
          state_d          = IDLE;
        end else if (!reqAny[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_request_arbiter
// Directed bench: dutA is the default 2-channel fixed-priority arbiter,
// dutB a 4-channel round-robin arbiter, and a standalone 3-channel
// round-robin picker is exercised on its wrap-around cases.
// ---------------------------------------------------------------------------
module tb_mem_request_arbiter;

  logic CLK = 1'b0;
  logic nRST;

  // Free-running 10-unit clock shared by both arbiters.
  always #5 CLK = ~CLK;

  logic [1:0]  renA, wenA, hitA;
  logic [63:0] addrA, storeA;
  logic [31:0] reqLoadA, memAddrA, memStoreA, loadA;
  logic        memRenA, memWenA, readyA, busyA;
  logic        grantA;

  logic [3:0]   renB, wenB, hitB;
  logic [127:0] addrB, storeB;
  logic [31:0]  reqLoadB, memAddrB, memStoreB, loadB;
  logic         memRenB, memWenB, readyB, busyB;
  logic [1:0]   grantB;

  logic [2:0] pkReq;
  logic [1:0] pkPtr, pkIdx, pkNext;
  logic       pkFound;

  int checks = 0;
  int errors = 0;

  mem_request_arbiter #(.NCH(2), .AW(32), .DW(32), .PRIO_MODE(1)) dutA (
    .CLK(CLK), .nRST(nRST),
    .req_ren(renA), .req_wen(wenA), .req_addr(addrA), .req_store(storeA),
    .req_hit(hitA), .req_load(reqLoadA),
    .mem_ren(memRenA), .mem_wen(memWenA), .mem_addr(memAddrA), .mem_store(memStoreA),
    .mem_ready(readyA), .mem_load(loadA),
    .busy(busyA), .grant_id(grantA)
  );

  mem_request_arbiter #(.NCH(4), .AW(32), .DW(32), .PRIO_MODE(0)) dutB (
    .CLK(CLK), .nRST(nRST),
    .req_ren(renB), .req_wen(wenB), .req_addr(addrB), .req_store(storeB),
    .req_hit(hitB), .req_load(reqLoadB),
    .mem_ren(memRenB), .mem_wen(memWenB), .mem_addr(memAddrB), .mem_store(memStoreB),
    .mem_ready(readyB), .mem_load(loadB),
    .busy(busyB), .grant_id(grantB)
  );

  rr_picker #(.NCH(3), .MODE(0)) picker (
    .req_i(pkReq), .ptr_i(pkPtr), .found_o(pkFound), .idx_o(pkIdx), .next_ptr_o(pkNext)
  );

  // One comparison: counted always, reported and counted as an error on miss.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive dutA's request/memory inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] ren, input logic [1:0] wen,
                               input logic ready, input logic [31:0] load);
    renA   = ren;
    wenA   = wen;
    readyA = ready;
    loadA  = load;
    #1;
  endtask

  // Move to just after the next falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Directed sequence: reset, picker wrap cases, then each arbiter scenario.
  initial begin
    logic [3:0] oneHot;
    int         expCh;

    nRST = 1'b0;
    renA = '0; wenA = '0; addrA = '0; storeA = '0; readyA = 1'b0; loadA = '0;
    renB = '0; wenB = '0; addrB = '0; storeB = '0; readyB = 1'b0; loadB = 32'h0000_600D;
    pkReq = '0; pkPtr = '0;
    for (int i = 0; i < 4; i++) begin
      addrB[i*32 +: 32]  = 32'h1000 + 32'(i * 16);
      storeB[i*32 +: 32] = 32'hB000 + 32'(i);
    end

    tick();
    checkOutput("reset_busyA", busyA, 0);
    checkOutput("reset_memRenA", memRenA, 0);
    checkOutput("reset_memWenA", memWenA, 0);
    checkOutput("reset_memAddrA", memAddrA, 0);
    checkOutput("reset_hitA", hitA, 0);
    checkOutput("reset_reqLoadA", reqLoadA, 0);
    checkOutput("reset_grantA", grantA, 0);
    checkOutput("reset_busyB", busyB, 0);
    checkOutput("reset_grantB", grantB, 0);
    checkOutput("reset_memStoreB", memStoreB, 0);

    pkReq = 3'b011; pkPtr = 2'd2; #1;
    checkOutput("pick_wrap_idx", pkIdx, 0);
    checkOutput("pick_wrap_next", pkNext, 1);
    pkReq = 3'b110; pkPtr = 2'd0; #1;
    checkOutput("pick_plain_idx", pkIdx, 1);
    checkOutput("pick_plain_next", pkNext, 2);
    pkReq = 3'b101; pkPtr = 2'd1; #1;
    checkOutput("pick_last_idx", pkIdx, 2);
    checkOutput("pick_last_next", pkNext, 0);
    checkOutput("pick_found", pkFound, 1);
    pkReq = 3'b000; #1;
    checkOutput("pick_none", pkFound, 0);

    @(negedge CLK);
    nRST = 1'b1;
    #1;

    // Single read on ch0, memory ready from the first BUSY cycle.
    addrA[31:0] = 32'h0000_0040;
    applyStimulus(2'b01, 2'b00, 1'b1, 32'hDEAD_BEEF);
    checkOutput("read_idle_memRen", memRenA, 0);
    tick();
    checkOutput("read_memRen", memRenA, 1);
    checkOutput("read_memAddr", memAddrA, 32'h40);
    checkOutput("read_hit", hitA, 2'b01);
    checkOutput("read_load", reqLoadA, 32'hDEAD_BEEF);
    checkOutput("read_busy", busyA, 1);
    applyStimulus(2'b00, 2'b00, 1'b1, 32'hDEAD_BEEF);
    tick();
    checkOutput("read_after_busy", busyA, 0);
    checkOutput("read_after_hit", hitA, 0);
    checkOutput("read_after_load", reqLoadA, 0);

    // Fixed priority: ch1 write beats ch0 read, then ch0 after one IDLE cycle.
    addrA  = {32'h0000_0200, 32'h0000_0100};
    storeA = {32'h1234_5678, 32'h0000_0000};
    applyStimulus(2'b01, 2'b10, 1'b1, 32'hCAFE_F00D);
    tick();
    checkOutput("prio_grant", grantA, 1);
    checkOutput("prio_memWen", memWenA, 1);
    checkOutput("prio_memRen", memRenA, 0);
    checkOutput("prio_memAddr", memAddrA, 32'h200);
    checkOutput("prio_memStore", memStoreA, 32'h1234_5678);
    checkOutput("prio_hit1", hitA, 2'b10);
    applyStimulus(2'b01, 2'b00, 1'b1, 32'hCAFE_F00D);
    tick();
    checkOutput("prio_idle_busy", busyA, 0);
    checkOutput("prio_idle_hit", hitA, 0);
    tick();
    checkOutput("prio_second_grant", grantA, 0);
    checkOutput("prio_second_memRen", memRenA, 1);
    checkOutput("prio_second_addr", memAddrA, 32'h100);
    checkOutput("prio_second_hit", hitA, 2'b01);
    checkOutput("prio_second_load", reqLoadA, 32'hCAFE_F00D);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    tick();

    // Stall: ch1 requests with both ren and wen (a write), memory held off
    // while ch1's address/data and ch0's request keep changing.
    addrA[63:32]  = 32'h0000_0300;
    storeA[63:32] = 32'hA5A5_0001;
    applyStimulus(2'b10, 2'b10, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_memWen", memWenA, 1);
      checkOutput("stall_memRen", memRenA, 0);
      checkOutput("stall_memAddr", memAddrA, 32'h300);
      checkOutput("stall_memStore", memStoreA, 32'hA5A5_0001);
      checkOutput("stall_hit", hitA, 0);
      addrA[63:32]  = 32'h0000_0300 + 32'((i + 1) * 4);
      storeA[63:32] = ~storeA[63:32];
      renA[0]       = ~renA[0];
    end
    tick();
    applyStimulus(2'b10, 2'b10, 1'b1, 32'h0000_55AA);
    checkOutput("stall_done_hit", hitA, 2'b10);
    checkOutput("stall_done_addr", memAddrA, 32'h300);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    tick();
    checkOutput("stall_after_hit", hitA, 0);
    checkOutput("stall_after_busy", busyA, 0);

    // Abort: ch0 drops its read in the third BUSY cycle.
    addrA[31:0] = 32'h0000_0080;
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h0);
    tick();
    checkOutput("abort_busy1", busyA, 1);
    checkOutput("abort_memRen1", memRenA, 1);
    tick();
    tick();
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    checkOutput("abort_cycle_hit", hitA, 0);
    tick();
    checkOutput("abort_idle_busy", busyA, 0);
    checkOutput("abort_idle_memRen", memRenA, 0);
    checkOutput("abort_idle_hit", hitA, 0);

    // Abort coinciding with mem_ready: the completion still wins.
    applyStimulus(2'b10, 2'b00, 1'b0, 32'h0);
    tick();
    checkOutput("abortrdy_grant", grantA, 1);
    applyStimulus(2'b00, 2'b00, 1'b1, 32'h1111_2222);
    checkOutput("abortrdy_hit", hitA, 2'b10);
    checkOutput("abortrdy_load", reqLoadA, 32'h1111_2222);
    tick();
    checkOutput("abortrdy_idle", busyA, 0);
    applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

    // Round-robin on dutB: all four channels request continuously.
    renB   = 4'hF;
    readyB = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      expCh  = g % 4;
      oneHot = 4'b0001 << expCh;
      tick();
      checkOutput("rr_grant", grantB, 64'(expCh));
      checkOutput("rr_hit", hitB, oneHot);
      checkOutput("rr_addr", memAddrB, 32'h1000 + 32'(expCh * 16));
      checkOutput("rr_load", reqLoadB, 32'h0000_600D);
      tick();
      checkOutput("rr_idle_hit", hitB, 0);
      checkOutput("rr_idle_busy", busyB, 0);
    end

    // Async reset mid-BUSY on both arbiters; dutB's pointer sits at 2 here.
    readyB      = 1'b0;
    addrA[31:0] = 32'h0000_0044;
    applyStimulus(2'b01, 2'b00, 1'b0, 32'h0);
    tick();
    checkOutput("arst_pre_busyA", busyA, 1);
    checkOutput("arst_pre_grantB", grantB, 2);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("arst_busyA", busyA, 0);
    checkOutput("arst_memRenA", memRenA, 0);
    checkOutput("arst_memWenA", memWenA, 0);
    checkOutput("arst_busyB", busyB, 0);
    checkOutput("arst_memRenB", memRenB, 0);
    checkOutput("arst_memWenB", memWenB, 0);
    renA = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    checkOutput("arst_ptr_grantB", grantB, 0);
    checkOutput("arst_ptr_addrB", memAddrB, 32'h1000);
    checkOutput("arst_idleA", busyA, 0);
    renB = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
